// File: rtl/rect_draw_datapath.sv
// rect_draw_datapath
//   Drawing datapath that sits behind the paint controller and feeds a 160x120
//   VGA adapter. It captures corner coordinates and a colour through the load
//   strobes. On a rectangle command (enable, alu_select=01) it rasterises the
//   filled rectangle between the two corners in row-major order. On a freeform
//   command (enable, alu_select=11) it plots the X1/Y1 pixel on every cycle.
//
// Ports
//   Clock, reset_N        : clock; asynchronous active-high reset
//   data_in[7:0]          : coordinate value (Y loads use data_in[6:0])
//   colour_in[2:0]        : RGB colour
//   loadX/loadY/loadX2/loadY2/loadC : capture strobes for X1/Y1/X2/Y2/C
//   enable, alu_select[1:0]: draw command (01 rectangle, 11 freeform)
//   x_out, y_out, colour_out, plot : VGA adapter pixel interface
//   busy                  : rectangle in progress (SETUP/SCAN/DONE)
//   done                  : one-cycle pulse after the last rectangle pixel
module rect_draw_datapath #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       Clock,
  input  logic       reset_N,
  input  logic [7:0] data_in,
  input  logic [2:0] colour_in,
  input  logic       loadX,
  input  logic       loadY,
  input  logic       loadX2,
  input  logic       loadY2,
  input  logic       loadC,
  input  logic       enable,
  input  logic [1:0] alu_select,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] X_LIM = X_MAX[7:0];
  localparam logic [6:0] Y_LIM = Y_MAX[6:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DONE,
    S_HOLD,
    S_FREE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x1_q, x1_d, x2_q, x2_d;
  logic [6:0] y1_q, y1_d, y2_q, y2_d;
  logic [2:0] c_q, c_d;
  logic [7:0] xmin_q, xmin_d, xmax_q, xmax_d, cx_q, cx_d;
  logic [6:0] ymin_q, ymin_d, ymax_q, ymax_d, cy_q, cy_d;
  logic [2:0] col_q, col_d;
  // Last driven pixel, so x/y/colour hold steady while plot is low.
  logic [7:0] x_hold_q, x_hold_d;
  logic [6:0] y_hold_q, y_hold_d;
  logic [2:0] c_hold_q, c_hold_d;

  logic [7:0] x_clamped;
  logic [6:0] y_clamped;
  logic       free_cmd;

  assign x_clamped = (data_in > X_LIM) ? X_LIM : data_in;
  assign y_clamped = (data_in[6:0] > Y_LIM) ? Y_LIM : data_in[6:0];
  assign free_cmd  = enable && (alu_select == 2'b11);

  // Next-state and datapath updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    c_d     = c_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;

    // Loads are independent and always accepted; a running scan works only
    // from the bounds it latched in SETUP.
    if (loadX)  x1_d = x_clamped;
    if (loadY)  y1_d = y_clamped;
    if (loadX2) x2_d = x_clamped;
    if (loadY2) y2_d = y_clamped;
    if (loadC)  c_d  = colour_in;

    case (state_q)
      S_IDLE: begin
        if (enable && alu_select == 2'b01) state_d = S_SETUP;
        else if (free_cmd)                 state_d = S_FREE;
      end
      S_SETUP: begin
        xmin_d  = (x1_q < x2_q) ? x1_q : x2_q;
        xmax_d  = (x1_q < x2_q) ? x2_q : x1_q;
        ymin_d  = (y1_q < y2_q) ? y1_q : y2_q;
        ymax_d  = (y1_q < y2_q) ? y2_q : y1_q;
        col_d   = c_q;
        cx_d    = (x1_q < x2_q) ? x1_q : x2_q;
        cy_d    = (y1_q < y2_q) ? y1_q : y2_q;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (cx_q == xmax_q) begin
          cx_d = xmin_q;
          if (cy_q == ymax_q) state_d = S_DONE;
          else                cy_d    = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      // A held enable parks in HOLD so the same command cannot retrigger.
      S_DONE:  state_d = enable ? S_HOLD : S_IDLE;
      S_HOLD:  if (!enable) state_d = S_IDLE;
      S_FREE:  if (!free_cmd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only: no input reaches plot directly.
  always_comb begin
    plot       = 1'b0;
    x_out      = x_hold_q;
    y_out      = y_hold_q;
    colour_out = c_hold_q;
    if (state_q == S_SCAN) begin
      plot       = 1'b1;
      x_out      = cx_q;
      y_out      = cy_q;
      colour_out = col_q;
    end else if (state_q == S_FREE) begin
      plot       = 1'b1;
      x_out      = x1_q;
      y_out      = y1_q;
      colour_out = c_q;
    end
    busy     = (state_q == S_SETUP) || (state_q == S_SCAN) || (state_q == S_DONE);
    done     = (state_q == S_DONE);
    x_hold_d = x_out;
    y_hold_d = y_out;
    c_hold_d = colour_out;
  end

  always_ff @(posedge Clock or posedge reset_N) begin
    if (reset_N) begin
      state_q  <= S_IDLE;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      c_q      <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_hold_q <= '0;
      y_hold_q <= '0;
      c_hold_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      c_q      <= c_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_hold_q <= x_hold_d;
      y_hold_q <= y_hold_d;
      c_hold_q <= c_hold_d;
    end
  end

endmodule
